// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory-port arbiter.
// Holds the FSM state encoding, requester ids and line-offset sizing helpers.
package mem_arb_pkg;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

   localparam logic REQ_I = 1'b0;
   localparam logic REQ_D = 1'b1;

   localparam int unsigned DEF_ADDR_W      = 32;
   localparam int unsigned DEF_LINE_W      = 256;
   localparam int unsigned DEF_TIMEOUT_CYC = 1023;

   function automatic int unsigned offset_w(input int unsigned line_w);
      return $clog2(line_w / 8);
   endfunction

   // A disabled watchdog still needs a one-bit counter to keep widths legal.
   function automatic int unsigned cnt_w(input int unsigned timeout_cyc);
      int unsigned w;
      w = $clog2(timeout_cyc + 1);
      return (w < 1) ? 1 : w;
   endfunction

   localparam int unsigned OFFSET_W = offset_w(DEF_LINE_W);

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: a lone request wins, a tie goes to the requester
// that did not win last time.
module rr_pick2
   import mem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic       grant_id,
   output logic       grant_valid
);

   always_comb begin
      grant_valid = |req;
      grant_id    = REQ_I;
      if (&req) begin
         grant_id = ~last_grant;
      end else if (req[REQ_D]) begin
         grant_id = REQ_D;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one line-wide memory port between the icache refill path and the dcache,
// running one latched transaction at a time with an optional watchdog.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W      = DEF_ADDR_W,
   parameter int unsigned LINE_W      = DEF_LINE_W,
   parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              i_req_i,
   input  logic [ADDR_W-1:0] i_addr_i,
   output logic              i_ack_o,
   output logic [LINE_W-1:0] i_data_o,
   input  logic              d_req_i,
   input  logic              d_write_i,
   input  logic [ADDR_W-1:0] d_addr_i,
   input  logic [LINE_W-1:0] d_data_i,
   output logic              d_ack_o,
   output logic [LINE_W-1:0] d_data_o,
   output logic              mem_enable_o,
   output logic              mem_write_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [LINE_W-1:0] mem_data_o,
   input  logic [LINE_W-1:0] mem_data_i,
   input  logic              mem_ack_i,
   output logic              err_o
);

   localparam int unsigned CNT_W = cnt_w(TIMEOUT_CYC);
   localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'((LINE_W / 8) - 1);

   state_e            state;
   logic              last_grant;
   logic              owner;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  cnt_nxt;
   logic              timeout_hit;
   logic              grant_id;
   logic              grant_valid;
   logic [ADDR_W-1:0] grant_addr;
   logic [LINE_W-1:0] rsp_data;

   rr_pick2 u_pick (
      .req         ({d_req_i, i_req_i}),
      .last_grant  (last_grant),
      .grant_id    (grant_id),
      .grant_valid (grant_valid)
   );

   // A same-cycle ack wins over the watchdog, so rsp_data only zeroes on a true abort.
   assign cnt_nxt     = cnt + CNT_W'(1);
   assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt_nxt == CNT_W'(TIMEOUT_CYC));
   assign grant_addr  = (grant_id == REQ_D) ? d_addr_i : i_addr_i;
   assign rsp_data    = mem_ack_i ? mem_data_i : '0;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state        <= IDLE;
         last_grant   <= REQ_I;
         owner        <= REQ_I;
         cnt          <= '0;
         mem_enable_o <= 1'b0;
         mem_write_o  <= 1'b0;
         mem_addr_o   <= '0;
         mem_data_o   <= '0;
         i_ack_o      <= 1'b0;
         d_ack_o      <= 1'b0;
         i_data_o     <= '0;
         d_data_o     <= '0;
         err_o        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_valid) begin
                  owner        <= grant_id;
                  last_grant   <= grant_id;
                  cnt          <= '0;
                  mem_enable_o <= 1'b1;
                  mem_addr_o   <= grant_addr & ADDR_MASK;
                  mem_write_o  <= (grant_id == REQ_D) && d_write_i;
                  mem_data_o   <= (grant_id == REQ_D) ? d_data_i : '0;
                  state        <= BUSY;
               end
            end
            BUSY: begin
               if (mem_ack_i || timeout_hit) begin
                  mem_enable_o <= 1'b0;
                  mem_write_o  <= 1'b0;
                  state        <= DONE;
                  if (!mem_ack_i) begin
                     err_o <= 1'b1;
                  end
                  if (owner == REQ_D) begin
                     d_ack_o  <= 1'b1;
                     d_data_o <= rsp_data;
                  end else begin
                     i_ack_o  <= 1'b1;
                     i_data_o <= rsp_data;
                  end
               end else begin
                  cnt <= cnt_nxt;
               end
            end
            DONE: begin
               i_ack_o <= 1'b0;
               d_ack_o <= 1'b0;
               state   <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table for grant/latch/ack behaviour
// plus hand sequences for gaps, round-robin streaming, reset and the watchdog.
module tb_mem_port_arbiter;

   localparam int unsigned AW = 32;
   localparam int unsigned LW = 256;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          i_req = 1'b0;
   logic [AW-1:0] i_addr = '0;
   logic          d_req = 1'b0;
   logic          d_write = 1'b0;
   logic [AW-1:0] d_addr = '0;
   logic [LW-1:0] d_wdata = '0;
   logic [LW-1:0] mem_rdata = '0;
   logic          mem_ack = 1'b0;

   logic          i_ack, d_ack, mem_enable, mem_write, err;
   logic [LW-1:0] i_data, d_data, mem_wdata;
   logic [AW-1:0] mem_addr;

   logic          t_i_ack, t_d_ack, t_mem_enable, t_mem_write, t_err;
   logic [LW-1:0] t_i_data, t_d_data, t_mem_wdata;
   logic [AW-1:0] t_mem_addr;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mem_port_arbiter dut (
      .clk_i (clk), .rst_i (rst),
      .i_req_i (i_req), .i_addr_i (i_addr), .i_ack_o (i_ack), .i_data_o (i_data),
      .d_req_i (d_req), .d_write_i (d_write), .d_addr_i (d_addr), .d_data_i (d_wdata),
      .d_ack_o (d_ack), .d_data_o (d_data),
      .mem_enable_o (mem_enable), .mem_write_o (mem_write), .mem_addr_o (mem_addr),
      .mem_data_o (mem_wdata), .mem_data_i (mem_rdata), .mem_ack_i (mem_ack),
      .err_o (err)
   );

   mem_port_arbiter #(.TIMEOUT_CYC(8)) dut_to (
      .clk_i (clk), .rst_i (rst),
      .i_req_i (i_req), .i_addr_i (i_addr), .i_ack_o (t_i_ack), .i_data_o (t_i_data),
      .d_req_i (d_req), .d_write_i (d_write), .d_addr_i (d_addr), .d_data_i (d_wdata),
      .d_ack_o (t_d_ack), .d_data_o (t_d_data),
      .mem_enable_o (t_mem_enable), .mem_write_o (t_mem_write), .mem_addr_o (t_mem_addr),
      .mem_data_o (t_mem_wdata), .mem_data_i (mem_rdata), .mem_ack_i (mem_ack),
      .err_o (t_err)
   );

   typedef struct {
      logic          i_req;
      logic          d_req;
      logic          d_write;
      logic [AW-1:0] i_addr;
      logic [AW-1:0] d_addr;
      logic [LW-1:0] d_data;
      int            lat;
      logic [LW-1:0] rdata;
      logic          exp_d;
      logic [AW-1:0] exp_addr;
      logic          exp_write;
      logic [LW-1:0] exp_wdata;
   } vec_t;

   vec_t vecs [6];

   function automatic vec_t mk(input logic ir, input logic dr, input logic dw,
                               input logic [AW-1:0] ia, input logic [AW-1:0] da,
                               input logic [LW-1:0] dd, input int lat,
                               input logic [LW-1:0] rd, input logic ed,
                               input logic [AW-1:0] ea, input logic ew,
                               input logic [LW-1:0] ewd);
      vec_t v;
      v.i_req = ir; v.d_req = dr; v.d_write = dw; v.i_addr = ia; v.d_addr = da;
      v.d_data = dd; v.lat = lat; v.rdata = rd; v.exp_d = ed; v.exp_addr = ea;
      v.exp_write = ew; v.exp_wdata = ewd;
      return v;
   endfunction

   task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   initial begin
      logic [LW-1:0] wb_pat;
      logic [LW-1:0] junk;
      bit            ok;
      wb_pat = {8{32'hDEADBEEF}};
      junk   = {8{32'hBAD0BAD0}};

      // Table starts from reset, so last grant = icache and the first tie goes to dcache.
      vecs[0] = mk(0, 1, 0, 32'h0, 32'h0000_0414, '0, 10, {8{32'h0A0A_0001}},
                   1, 32'h0000_0400, 0, '0);
      vecs[1] = mk(1, 0, 0, 32'h1234_567F, 32'h0, '0, 3, {8{32'h0B0B_0002}},
                   0, 32'h1234_5660, 0, '0);
      vecs[2] = mk(1, 1, 1, 32'h0000_1000, 32'h8000_003C, wb_pat, 2, {8{32'h0C0C_0003}},
                   1, 32'h8000_0020, 1, wb_pat);
      vecs[3] = mk(1, 1, 1, 32'hFFFF_FFFF, 32'h0000_0040, wb_pat, 1, {8{32'h0D0D_0004}},
                   0, 32'hFFFF_FFE0, 0, '0);
      vecs[4] = mk(0, 1, 1, 32'h0, 32'h0000_0020, {8{32'h1357_9BDF}}, 0, {8{32'h0E0E_0005}},
                   1, 32'h0000_0020, 1, {8{32'h1357_9BDF}});
      vecs[5] = mk(1, 1, 0, 32'h0000_3000, 32'h0000_4000, '0, 4, {8{32'h0F0F_0006}},
                   0, 32'h0000_3000, 0, '0);

      do_reset();
      chk("reset_outs", LW'({i_ack, d_ack, mem_enable, mem_write, err}), '0);
      chk("reset_addr", LW'(mem_addr), '0);
      chk("reset_wdata", mem_wdata, '0);
      chk("reset_rdata", i_data | d_data, '0);
      chk("reset_to_outs", LW'({t_i_ack, t_d_ack, t_mem_enable, t_err}), '0);

      // Tie right after reset: dcache then icache, one IDLE cycle between.
      i_addr = 32'h0000_1000; d_addr = 32'h0000_2000; i_req = 1; d_req = 1;
      step();
      chk("tie_first_d_addr", LW'(mem_addr), LW'(32'h0000_2000));
      mem_ack = 1; mem_rdata = {8{32'h2222_0000}};
      step();
      mem_ack = 0; mem_rdata = junk;
      chk("tie_first_d_ack", LW'({d_ack, i_ack}), LW'(2'b10));
      chk("tie_done_enable_low", LW'(mem_enable), '0);
      d_req = 0;
      step();
      chk("tie_idle_enable_low", LW'(mem_enable), '0);
      step();
      chk("tie_second_enable", LW'(mem_enable), LW'(1));
      chk("tie_second_i_addr", LW'(mem_addr), LW'(32'h0000_1000));
      mem_ack = 1; mem_rdata = {8{32'h3333_0000}};
      step();
      mem_ack = 0; mem_rdata = junk;
      chk("tie_second_i_ack", LW'({d_ack, i_ack}), LW'(2'b01));
      chk("tie_second_i_data", i_data, {8{32'h3333_0000}});
      i_req = 0;
      step();

      do_reset();
      for (int v = 0; v < 6; v++) begin
         i_req = vecs[v].i_req; d_req = vecs[v].d_req; d_write = vecs[v].d_write;
         i_addr = vecs[v].i_addr; d_addr = vecs[v].d_addr; d_wdata = vecs[v].d_data;
         step();
         chk($sformatf("v%0d_enable", v), LW'(mem_enable), LW'(1));
         chk($sformatf("v%0d_addr", v), LW'(mem_addr), LW'(vecs[v].exp_addr));
         chk($sformatf("v%0d_write", v), LW'(mem_write), LW'(vecs[v].exp_write));
         chk($sformatf("v%0d_wdata", v), mem_wdata, vecs[v].exp_wdata);
         ok = 1;
         repeat (vecs[v].lat) begin
            step();
            if (mem_enable !== 1'b1 || mem_addr !== vecs[v].exp_addr ||
                mem_write !== vecs[v].exp_write || mem_wdata !== vecs[v].exp_wdata ||
                i_ack !== 1'b0 || d_ack !== 1'b0)
               ok = 0;
         end
         chk($sformatf("v%0d_busy_hold", v), LW'(ok), LW'(1));
         mem_ack = 1; mem_rdata = vecs[v].rdata;
         step();
         mem_ack = 0; mem_rdata = junk;
         chk($sformatf("v%0d_acks", v), LW'({d_ack, i_ack}),
             LW'({vecs[v].exp_d, ~vecs[v].exp_d}));
         chk($sformatf("v%0d_rdata", v), vecs[v].exp_d ? d_data : i_data, vecs[v].rdata);
         chk($sformatf("v%0d_done_mem", v), LW'({mem_enable, mem_write}), '0);
         i_req = 0; d_req = 0;
         step();
         chk($sformatf("v%0d_ack_pulse", v), LW'({d_ack, i_ack}), '0);
         chk($sformatf("v%0d_rdata_hold", v), vecs[v].exp_d ? d_data : i_data, vecs[v].rdata);
      end

      // Both requesters stay asserted: grants alternate D, I, D, I, D, I.
      do_reset();
      d_write = 0; i_addr = 32'h0000_0100; d_addr = 32'h0000_0200; i_req = 1; d_req = 1;
      for (int t = 0; t < 6; t++) begin
         step();
         chk($sformatf("rr%0d_addr", t), LW'(mem_addr),
             (t % 2 == 0) ? LW'(32'h0000_0200) : LW'(32'h0000_0100));
         mem_ack = 1; mem_rdata = LW'(t + 1);
         step();
         mem_ack = 0;
         chk($sformatf("rr%0d_acks", t), LW'({d_ack, i_ack}),
             (t % 2 == 0) ? LW'(2'b10) : LW'(2'b01));
         step();
      end

      // Reset mid-BUSY after a dcache win: outputs clear, no ack, next tie again goes to dcache.
      step();
      chk("pre_reset_grant_d", LW'(mem_addr), LW'(32'h0000_0200));
      step();
      step();
      rst = 1;
      step();
      rst = 0;
      chk("rst_mid_ctrl", LW'({i_ack, d_ack, mem_enable, mem_write, err}), '0);
      chk("rst_mid_addr", LW'(mem_addr), '0);
      chk("rst_mid_data", mem_wdata | i_data | d_data, '0);
      step();
      chk("post_reset_tie_d", LW'(mem_addr), LW'(32'h0000_0200));
      chk("post_reset_no_ack", LW'({i_ack, d_ack}), '0);
      mem_ack = 1;
      step();
      mem_ack = 0; i_req = 0; d_req = 0;
      step();
      step();

      // Watchdog instance (TIMEOUT_CYC = 8).
      do_reset();
      d_write = 0; d_addr = 32'h0000_0040; d_req = 1;
      step();
      chk("to_normal_enable", LW'(t_mem_enable), LW'(1));
      mem_ack = 1; mem_rdata = {8{32'h4444_0000}};
      step();
      mem_ack = 0; mem_rdata = junk;
      chk("to_normal_ack", LW'(t_d_ack), LW'(1));
      chk("to_normal_data", t_d_data, {8{32'h4444_0000}});
      d_req = 0;
      step();

      // Ack in the 8th BUSY cycle still completes normally.
      d_req = 1;
      step();
      repeat (7) step();
      mem_ack = 1; mem_rdata = {8{32'h5555_0000}};
      step();
      mem_ack = 0; mem_rdata = junk;
      chk("to_edge_ack", LW'(t_d_ack), LW'(1));
      chk("to_edge_no_err", LW'(t_err), '0);
      chk("to_edge_data", t_d_data, {8{32'h5555_0000}});
      d_req = 0;
      step();

      // No ack at all: abort after 8 BUSY cycles.
      d_req = 1;
      step();
      ok = 1;
      repeat (7) begin
         step();
         if (t_err !== 1'b0 || t_mem_enable !== 1'b1 || t_d_ack !== 1'b0) ok = 0;
      end
      chk("to_busy_8_cycles", LW'(ok), LW'(1));
      step();
      chk("to_err_set", LW'(t_err), LW'(1));
      chk("to_abort_ack", LW'({t_d_ack, t_i_ack}), LW'(2'b10));
      chk("to_abort_data", t_d_data, '0);
      chk("to_abort_enable", LW'(t_mem_enable), '0);
      d_req = 0;
      step();
      chk("to_ack_pulse", LW'(t_d_ack), '0);
      chk("to_err_sticky", LW'(t_err), LW'(1));
      step();

      i_addr = 32'h0000_0080; i_req = 1;
      step();
      chk("to_after_enable", LW'(t_mem_enable), LW'(1));
      chk("to_after_addr", LW'(t_mem_addr), LW'(32'h0000_0080));
      mem_ack = 1; mem_rdata = {8{32'h6666_0000}};
      step();
      mem_ack = 0; mem_rdata = junk;
      chk("to_after_i_ack", LW'(t_i_ack), LW'(1));
      chk("to_after_i_data", t_i_data, {8{32'h6666_0000}});
      chk("to_after_err_sticky", LW'(t_err), LW'(1));
      i_req = 0;
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
